serial_addsub_bcd: RTL and testbench

//  Parametrised, bit-serial add/subtract unit with built-in sequential binary-to-BCD conversion.

---
 rtl/serial_addsub_bcd_pkg.sv | 19 +
 rtl/serial_addsub_bcd_cell.sv | 22 ++
 rtl/serial_addsub_bcd.sv | 185 ++++++++++++++++++
 tb/tb_serial_addsub_bcd.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_bcd_pkg.sv
// Shared definitions for the bit-serial add/subtract unit and its BCD converter.
package serial_addsub_bcd_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_CONV = 2'd3
    } state_e;

    // Double-dabble digit correction applied before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/serial_addsub_bcd_cell.sv
// One-bit full adder / full subtractor slice used by the serial datapath.
module addsub_bit_cell
    import serial_addsub_bcd_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    always_comb begin
        s = x ^ y ^ cin;
        if (mode == MODE_ADD) begin
            cout = (x & y) | (cin & (x ^ y));
        end else begin
            cout = (~x & (y | cin)) | (x & y & cin);
        end
    end

endmodule

// File: rtl/serial_addsub_bcd.sv
// Bit-serial add/subtract with flags and sequential sign+magnitude binary-to-BCD conversion.
module serial_addsub_bcd
    import serial_addsub_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  carry_borrow,
    output logic                  overflow,
    output logic                  negative,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + WIDTH + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic               mode_q, mode_d, cy_q, cy_d;
    logic [SW-1:0]      sh_q, sh_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cb_q, cb_d, ovf_q, ovf_d, neg_q, neg_d;
    logic [BW-1:0]      bcd_q, bcd_d;

    logic               cell_s, cell_cout;
    logic [SW-1:0]      sh_adj, sh_next;
    logic [WIDTH-1:0]   r_neg;
    logic [WIDTH:0]     mag;
    logic               ovf_c;

    addsub_bit_cell u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (cy_q),
        .mode (mode_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // One double-dabble step: correct every digit, then shift left.
    always_comb begin
        sh_adj = sh_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            sh_adj[WIDTH+1+4*i +: 4] = dd_adjust(sh_q[WIDTH+1+4*i +: 4]);
        end
        sh_next = sh_adj << 1;
    end

    // Flags and magnitude from the held operands (rotated back to original by end of CALC).
    always_comb begin
        r_neg = ~r_q + WIDTH'(1);
        if (mode_q == MODE_ADD) begin
            ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_q[WIDTH-1] != a_q[WIDTH-1]);
            mag   = {cy_q, r_q};
        end else begin
            ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_q[WIDTH-1] != a_q[WIDTH-1]);
            mag   = cy_q ? {1'b0, r_neg} : {1'b0, r_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        mode_d   = mode_q;
        cy_d     = cy_q;
        sh_d     = sh_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        bcd_d    = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Operands rotate so bit 0 feeds the cell and they are intact after WIDTH steps.
                r_d  = {cell_s, r_q[WIDTH-1:1]};
                cy_d = cell_cout;
                a_d  = {a_q[0], a_q[WIDTH-1:1]};
                b_d  = {b_q[0], b_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FIX: begin
                sh_d    = {BW'(0), mag};
                cnt_d   = '0;
                state_d = ST_CONV;
            end
            ST_CONV: begin
                sh_d = sh_next;
                if (cnt_q == CW'(WIDTH)) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = r_q;
                    cb_d     = cy_q;
                    ovf_d    = ovf_c;
                    neg_d    = (mode_q == MODE_SUB) && cy_q;
                    bcd_d    = sh_next[SW-1 -: BW];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            mode_q   <= MODE_ADD;
            cy_q     <= 1'b0;
            sh_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            mode_q   <= mode_d;
            cy_q     <= cy_d;
            sh_q     <= sh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            bcd_q    <= bcd_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign carry_borrow = cb_q;
    assign overflow     = ovf_q;
    assign negative     = neg_q;
    assign bcd          = bcd_q;

endmodule

// File: tb/tb_serial_addsub_bcd.sv
// Directed bench for serial_addsub_bcd: 8-bit vectors plus an exhaustive 4-bit sweep.
module tb_serial_addsub_bcd;

    logic        clk;
    logic        rst;

    logic        start8, mode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cb8, ov8, neg8;
    logic [7:0]  result8;
    logic [11:0] bcd8;

    logic        start4, mode4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, cb4, ov4, neg4;
    logic [3:0]  result4;
    logic [7:0]  bcd4;

    int n_assert = 0;
    int n_fail   = 0;

    serial_addsub_bcd #(.WIDTH(8), .DIGITS(3)) dut8 (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .start        (start8),
        .mode         (mode8),
        .a            (a8),
        .b            (b8),
        .busy         (busy8),
        .done         (done8),
        .result       (result8),
        .carry_borrow (cb8),
        .overflow     (ov8),
        .negative     (neg8),
        .bcd          (bcd8)
    );

    serial_addsub_bcd #(.WIDTH(4), .DIGITS(2)) dut4 (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .start        (start4),
        .mode         (mode4),
        .a            (a4),
        .b            (b4),
        .busy         (busy4),
        .done         (done4),
        .result       (result4),
        .carry_borrow (cb4),
        .overflow     (ov4),
        .negative     (neg4),
        .bcd          (bcd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs8(input string tag, input logic [7:0] er, input logic ecb,
                               input logic eov, input logic eneg, input logic [11:0] ebcd);
        check({tag, "_result"}, 32'(result8), 32'(er));
        check({tag, "_cb"},     32'(cb8),     32'(ecb));
        check({tag, "_ovf"},    32'(ov8),     32'(eov));
        check({tag, "_neg"},    32'(neg8),    32'(eneg));
        check({tag, "_bcd"},    32'(bcd8),    32'(ebcd));
    endtask

    // Issue one 8-bit op, check latency, held outputs mid-op, final outputs and pulse width.
    task automatic run8(input string tag, input logic m, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ecb, input logic eov, input logic eneg,
                        input logic [11:0] ebcd);
        int n;
        logic [7:0] held;
        held   = result8;
        mode8  = m;
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        n = 0;
        while (!done8 && n < 60) begin
            tick();
            n++;
            if (n == 10) check({tag, "_held"}, 32'(result8), 32'(held));
        end
        check({tag, "_latency"}, 32'(n), 32'd18);
        check({tag, "_busy_done"}, 32'(busy8), 32'd0);
        check_outs8(tag, er, ecb, eov, eneg, ebcd);
        tick();
        check({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int n;
        int sa, sb, ss, mag, eres, ecb, eov, eneg;
        logic [14:0] exp4;

        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check_outs8("reset", 8'h00, 1'b0, 1'b0, 1'b0, 12'h000);
        rst = 1'b0;
        tick();

        // Directed 8-bit vectors
        run8("add_200_100", 1'b0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1'b0, 12'h300);
        run8("sub_5_9",     1'b1, 8'd5,   8'd9,   8'hFC, 1'b1, 1'b0, 1'b1, 12'h004);
        run8("sub_80_01",   1'b1, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0, 12'h127);
        run8("add_7f_01",   1'b0, 8'h7F,  8'h01,  8'h80, 1'b0, 1'b1, 1'b0, 12'h128);
        run8("add_ff_ff",   1'b0, 8'hFF,  8'hFF,  8'hFE, 1'b1, 1'b0, 1'b0, 12'h510);
        run8("sub_0_ff",    1'b1, 8'h00,  8'hFF,  8'h01, 1'b1, 1'b0, 1'b1, 12'h255);
        run8("sub_7_7",     1'b1, 8'd7,   8'd7,   8'h00, 1'b0, 1'b0, 1'b0, 12'h000);

        // start held high; operands changed mid-op
        mode8 = 1'b0; a8 = 8'd100; b8 = 8'd23; start8 = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 5) begin
                mode8 = 1'b1; a8 = 8'd50; b8 = 8'd60;
            end
            if (done8) done_cnt++;
            if (i == 18) begin
                check("hold_done_first", 32'(done8), 32'd1);
                check_outs8("hold_first", 8'h7B, 1'b0, 1'b0, 1'b0, 12'h123);
            end
            if (i == 37) begin
                check("hold_done_second", 32'(done8), 32'd1);
                check_outs8("hold_second", 8'hF6, 1'b1, 1'b0, 1'b1, 12'h010);
            end
        end
        check("hold_done_count", 32'(done_cnt), 32'd2);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 60) begin
            tick();
            n++;
        end
        check("hold_third_done", 32'(done8), 32'd1);
        check_outs8("hold_third", 8'hF6, 1'b1, 1'b0, 1'b1, 12'h010);
        tick();

        // Reset during CONV aborts the op
        mode8 = 1'b0; a8 = 8'd99; b8 = 8'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy8), 32'd0);
        check("rst_mid_done", 32'(done8), 32'd0);
        check_outs8("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 12'h000);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        run8("after_rst", 1'b0, 8'd99, 8'd1, 8'd100, 1'b0, 1'b0, 1'b0, 12'h100);

        // Exhaustive WIDTH=4, DIGITS=2 sweep against an integer model
        for (int m = 0; m < 2; m++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    sa = (ai >= 8) ? ai - 16 : ai;
                    sb = (bi >= 8) ? bi - 16 : bi;
                    if (m == 0) begin
                        mag  = ai + bi;
                        eres = mag % 16;
                        ecb  = (mag >= 16) ? 1 : 0;
                        ss   = sa + sb;
                        eneg = 0;
                    end else begin
                        eres = (ai - bi + 16) % 16;
                        ecb  = (ai < bi) ? 1 : 0;
                        ss   = sa - sb;
                        eneg = ecb;
                        mag  = (ai < bi) ? bi - ai : ai - bi;
                    end
                    eov  = (ss > 7 || ss < -8) ? 1 : 0;
                    exp4 = {4'(eres), 1'(ecb), 1'(eov), 1'(eneg), 4'(mag / 10), 4'(mag % 10)};
                    mode4 = 1'(m); a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 40) begin
                        tick();
                        n++;
                    end
                    check("w4_latency", 32'(n), 32'd10);
                    check("w4_outputs", 32'({result4, cb4, ov4, neg4, bcd4}), 32'(exp4));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
